norm_shifter8: RTL and testbench

- Sequential 8-bit normalizer. It left-shifts an accepted operand until the leading significant bit reaches bit 7, then returns the normalized value and the shift amount.
- It is the inverse direction of the 8-bit combinational barrel shifter: that block consumes (data, shamt), this block produces them.
- Supports unsigned (leading-zero) and signed (leading-sign) normalization.
- Valid/ready on both sides; sits in front of the shifter or ALU datapath.

---
 rtl/norm_shifter8.sv | 214 +++++++++++++++++++++
 tb/tb_norm_shifter8.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_shifter8.sv
// norm_shifter8 -- sequential 8-bit normalizer with valid/ready on both sides.
//
// Left-shifts an accepted operand until its leading significant bit sits in
// bit 7 and returns the normalized value plus the number of shifts applied.
// signed_mode=0 normalizes on leading zeros, signed_mode=1 on leading sign
// bits. A zero operand short-circuits straight to DONE with zero=1.
//
// Build option: define NORM_FAST_EN to replace the one-bit-per-cycle SHIFT
// loop with a priority encoder evaluated at acceptance. DONE is then entered
// on the accepting edge for every operand; results are bit-identical.
//
// All outputs come straight from flops.

module norm_shifter8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] din,
  input  logic       signed_mode,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] dout,
  output logic [2:0] shamt,
  output logic       zero
);

`ifdef NORM_FAST_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
`endif

  // True when w is already normalized for the selected mode: the top bit is
  // set (unsigned) or the top two bits differ (signed).
  function automatic logic norm_stop(input logic [7:0] w, input logic sm);
    logic stop;
    if (sm) begin
      stop = (w[7] != w[6]);
    end else begin
      stop = w[7];
    end
    return stop;
  endfunction

`ifdef NORM_FAST_EN
  // Priority encoder: smallest shift k (0..6) that normalizes d, else 7.
  // Mirrors the iterative loop, which also stops at a count of 7.
  function automatic logic [2:0] lead_shift(input logic [7:0] d, input logic sm);
    logic [2:0] amt;
    logic       found;
    logic [7:0] cand;
    amt   = 3'd7;
    found = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cand = d << k;
      if (!found && norm_stop(cand, sm)) begin
        amt   = k[2:0];
        found = 1'b1;
      end
    end
    return amt;
  endfunction
`endif

  state_t     state_q, state_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] dout_q, dout_d;
  logic [2:0] shamt_q, shamt_d;
  logic       zero_q, zero_d;

`ifdef NORM_FAST_EN
  logic [2:0] fast_amt_s;
  logic [7:0] fast_val_s;

  assign fast_amt_s = lead_shift(din, signed_mode);
  assign fast_val_s = din << fast_amt_s;
`else
  logic [7:0] work_q, work_d;
  logic [2:0] cnt_q, cnt_d;
  logic       smode_q, smode_d;
  logic       stop_s;

  // Evaluation of the current work value; a count of 7 also ends the loop
  // so the counter can never wrap.
  assign stop_s = norm_stop(work_q, smode_q) || (cnt_q == 3'd7);
`endif

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    shamt_d     = shamt_q;
    zero_d      = zero_q;
`ifndef NORM_FAST_EN
    work_d      = work_q;
    cnt_d       = cnt_q;
    smode_d     = smode_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
`ifndef NORM_FAST_EN
          work_d     = din;
          cnt_d      = 3'd0;
          smode_d    = signed_mode;
`endif
          if (din == 8'h00) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            dout_d      = 8'h00;
            shamt_d     = 3'd0;
            zero_d      = 1'b1;
          end else begin
`ifdef NORM_FAST_EN
            state_d     = DONE;
            out_valid_d = 1'b1;
            dout_d      = fast_val_s;
            shamt_d     = fast_amt_s;
            zero_d      = 1'b0;
`else
            state_d     = SHIFT;
`endif
          end
        end else begin
          // Also raises in_ready on the first edge out of reset.
          in_ready_d = 1'b1;
        end
      end
`ifndef NORM_FAST_EN
      SHIFT: begin
        if (stop_s) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          dout_d      = work_q;
          shamt_d     = cnt_q;
          zero_d      = 1'b0;
        end else begin
          work_d = {work_q[6:0], 1'b0};
          cnt_d  = cnt_q + 3'd1;
        end
      end
`endif
      DONE: begin
        // Result is held until the consumer takes it; no operand is accepted
        // on the handshake edge itself.
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d     = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; asynchronous reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= 8'h00;
      shamt_q     <= 3'd0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      shamt_q     <= shamt_d;
      zero_q      <= zero_d;
    end
  end

`ifndef NORM_FAST_EN
  // Working datapath registers for the iterative shift loop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q  <= 8'h00;
      cnt_q   <= 3'd0;
      smode_q <= 1'b0;
    end else begin
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      smode_q <= smode_d;
    end
  end
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign shamt     = shamt_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_norm_shifter8.sv
// Testbench for norm_shifter8: directed vectors with literal expectations,
// plus an arithmetic reference model and a scoreboard checked every cycle.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge by the monitor and 1 time unit after the edge by tasks.

module tb_norm_shifter8;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic       signed_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dout;
  logic [2:0] shamt;
  logic       zero;

  int n_tests   = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int n_results = 0;

  typedef struct {
    logic [7:0] d;
    logic [2:0] s;
    logic       z;
    int         acc;
    int         lat;
  } exp_t;

  exp_t sb[$];
  bit   front_seen = 1'b0;

  norm_shifter8 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .din         (din),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dout        (dout),
    .shamt       (shamt),
    .zero        (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: treat the operand as a number and double it while it still
  // fits after doubling (unsigned < 128, signed within [-64,63]), max 7 times.
  // Returns {dout, shamt, zero}.
  function automatic logic [11:0] model(input logic [7:0] d, input logic sm);
    int v;
    int k;
    logic [7:0] res;
    k = 0;
    if (d == 8'h00) return {8'h00, 3'd0, 1'b1};
    if (sm) begin
      v = int'($signed(d));
      while (k < 7 && v >= -64 && v < 64) begin
        v = v * 2;
        k++;
      end
    end else begin
      v = int'(d);
      while (k < 7 && v < 128) begin
        v = v * 2;
        k++;
      end
    end
    res = v[7:0];
    return {res, k[2:0], 1'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic sm);
    int t;
    t = 0;
    while (!in_ready && t < 40) begin
      tick();
      t++;
    end
    chk("send_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid    = 1'b1;
    din         = d;
    signed_mode = sm;
    tick();
    in_valid    = 1'b0;
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!out_valid && t < 40) begin
      tick();
      t++;
    end
    chk("wait_out_valid", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic run_one(input string name, input logic [7:0] d, input logic sm,
                         input logic [7:0] ed, input logic [2:0] es, input logic ez);
    out_ready = 1'b0;
    send(d, sm);
    wait_valid();
    chk({name, "_dout"}, {24'd0, dout}, {24'd0, ed});
    chk({name, "_shamt"}, {29'd0, shamt}, {29'd0, es});
    chk({name, "_zero"}, {31'd0, zero}, {31'd0, ez});
    out_ready = 1'b1;
    tick();
    chk({name, "_hs_clear"}, {30'd0, out_valid, in_ready}, 32'd1);
    out_ready = 1'b0;
  endtask

  // Scoreboard monitor: checks outputs every cycle they are valid, measures
  // latency from the accepting edge (counted as edge 1), tracks handshakes.
  initial begin : monitor
    exp_t e;
    logic [11:0] r;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        sb.delete();
        front_seen = 1'b0;
      end else begin
        if (out_valid) begin
          if (sb.size() == 0) begin
            chk("mon_stale_result", {31'd0, out_valid}, 32'd0);
          end else begin
            e = sb[0];
            chk("mon_dout", {24'd0, dout}, {24'd0, e.d});
            chk("mon_shamt", {29'd0, shamt}, {29'd0, e.s});
            chk("mon_zero", {31'd0, zero}, {31'd0, e.z});
            if (!front_seen) begin
              chk("mon_latency", cyc - e.acc, e.lat);
              front_seen = 1'b1;
            end
            if (out_ready) begin
              e = sb.pop_front();
              front_seen = 1'b0;
              n_results++;
            end
          end
        end
        if (in_valid && in_ready) begin
          r     = model(din, signed_mode);
          e.d   = r[11:4];
          e.s   = r[3:1];
          e.z   = r[0];
          e.acc = cyc;
`ifdef NORM_FAST_EN
          e.lat = 1;
`else
          e.lat = e.z ? 1 : int'(e.s) + 2;
`endif
          sb.push_back(e);
        end
      end
    end
  end

  initial begin : stim
    int base;
    int t;
    int seen;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    din         = 8'h00;
    signed_mode = 1'b0;
    out_ready   = 1'b0;
    tick();
    tick();

    // Reset state.
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_shamt", {29'd0, shamt}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    tick();
    chk("rel_in_ready_after_edge", {31'd0, in_ready}, 32'd1);

    // Pin the reference model with hand-computed values.
    chk("model_13u", {20'd0, model(8'h13, 1'b0)}, {20'd0, 8'h98, 3'd3, 1'b0});
    chk("model_f3s", {20'd0, model(8'hF3, 1'b1)}, {20'd0, 8'h98, 3'd3, 1'b0});
    chk("model_ffs", {20'd0, model(8'hFF, 1'b1)}, {20'd0, 8'h80, 3'd7, 1'b0});
    chk("model_01u", {20'd0, model(8'h01, 1'b0)}, {20'd0, 8'h80, 3'd7, 1'b0});
    chk("model_40s", {20'd0, model(8'h40, 1'b1)}, {20'd0, 8'h40, 3'd0, 1'b0});
    chk("model_00s", {20'd0, model(8'h00, 1'b1)}, {20'd0, 8'h00, 3'd0, 1'b1});

    // Directed vectors with literal expectations.
    run_one("v13u", 8'h13, 1'b0, 8'h98, 3'd3, 1'b0);
    run_one("v00u", 8'h00, 1'b0, 8'h00, 3'd0, 1'b1);
    run_one("v00s", 8'h00, 1'b1, 8'h00, 3'd0, 1'b1);
    run_one("vf3s", 8'hF3, 1'b1, 8'h98, 3'd3, 1'b0);
    run_one("vffs", 8'hFF, 1'b1, 8'h80, 3'd7, 1'b0);
    run_one("v01u", 8'h01, 1'b0, 8'h80, 3'd7, 1'b0);
    run_one("v80u", 8'h80, 1'b0, 8'h80, 3'd0, 1'b0);
    run_one("v40s", 8'h40, 1'b1, 8'h40, 3'd0, 1'b0);
    run_one("v01s", 8'h01, 1'b1, 8'h40, 3'd6, 1'b0);
    run_one("vc0s", 8'hC0, 1'b1, 8'h80, 3'd1, 1'b0);
    run_one("v80s", 8'h80, 1'b1, 8'h80, 3'd0, 1'b0);
    run_one("v05u", 8'h05, 1'b0, 8'hA0, 3'd5, 1'b0);

    // Backpressure: result held, new operand refused while in DONE.
    out_ready = 1'b0;
    send(8'h80, 1'b0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        in_valid    = 1'b1;
        din         = 8'h13;
        signed_mode = 1'b0;
      end
      tick();
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_dout", {24'd0, dout}, 32'h80);
      chk("bp_shamt", {29'd0, shamt}, 32'd0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release", {30'd0, out_valid, in_ready}, 32'd1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    din       = 8'h13;
    tick();
    in_valid  = 1'b0;
    chk("bp_next_accepted", {31'd0, in_ready}, 32'd0);
    wait_valid();
    chk("bp_next_dout", {24'd0, dout}, 32'h98);
    chk("bp_next_shamt", {29'd0, shamt}, 32'd3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of a shift sequence.
    send(8'h01, 1'b0);
    tick();
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_in_ready_rel", {31'd0, in_ready}, 32'd0);
    tick();
    chk("midrst_in_ready_edge", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("midrst_no_stale", seen, 32'd0);

    // Back-to-back with the consumer always ready.
    out_ready = 1'b1;
    base = n_results;
    send(8'h13, 1'b0);
    send(8'hF3, 1'b1);
    t = 0;
    while ((n_results - base) < 2 && t < 60) begin
      tick();
      t++;
    end
    chk("b2b_results", n_results - base, 32'd2);
    out_ready = 1'b0;
    tick();
    tick();

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
